lock_key_loader: RTL and testbench

//   Provisions the working_locking_key bus consumed by the team's logic-locked

---
 rtl/lock_pkg.sv | 21 ++
 rtl/lock_key_loader.sv | 151 +++++++++++++++
 tb/tb_lock_key_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the key loader: FSM state encoding, default key width, parity helper.
package lock_pkg;

    localparam int DEFAULT_KEY_WIDTH = 8;
    // The parity helper accepts keys up to this width; narrower keys are zero-extended.
    localparam int MAX_KEY_WIDTH     = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // True when data bits plus the trailing parity bit have an even number of ones.
    function automatic logic even_parity_ok(input logic [MAX_KEY_WIDTH-1:0] data,
                                            input logic                     pbit);
        return ((^data) ^ pbit) == 1'b0;
    endfunction

endpackage

// File: rtl/lock_key_loader.sv
// Serial LSB-first key loader with even-parity commit. Key updates one cycle after the parity beat.
// Backpressure: key_ready is a registered-state decode, high only while a load is in progress.
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_bit,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [KEY_WIDTH-1:0] working_locking_key,
    output logic                 key_loaded,
    output logic                 key_error,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(KEY_WIDTH + 1);
    localparam int                TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(KEY_WIDTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [KEY_WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [KEY_WIDTH-1:0]   r_key;
    logic                   r_loaded;
    logic                   r_error;

    logic                   w_busy;
    logic                   w_beat;
    logic                   w_start;
    logic                   w_shift_beat;
    logic                   w_commit;
    logic                   w_fail;
    logic                   w_to_hit;
    logic                   w_par_ok;

    assign w_busy       = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign w_beat       = key_valid && w_busy;
    assign w_shift_beat = w_beat && (r_state == ST_SHIFT);
    assign w_to_hit     = TO_EN && w_busy && !w_beat && (r_to_cnt == TO_LAST);
    assign w_par_ok     = even_parity_ok(MAX_KEY_WIDTH'(r_shreg), key_bit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (load_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_beat) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = ST_PARITY;
                    end
                end else if (w_to_hit) begin
                    w_fail      = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_PARITY: begin
                if (w_beat) begin
                    if (w_par_ok) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_ERROR;
                    end
                end else if (w_to_hit) begin
                    w_fail      = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Load datapath: shift register, beat counter and idle-cycle timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_beat) begin
                for (int i = 0; i < KEY_WIDTH; i++) begin
                    if (r_bit_cnt == CNT_W'(i)) begin
                        r_shreg[i] <= key_bit;
                    end
                end
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_start || w_beat || !w_busy || w_to_hit) begin
                r_to_cnt <= '0;
            end else if (TO_EN) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Committed outputs: the old key survives any failed reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key    <= '0;
            r_loaded <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_key    <= r_shreg;
                r_loaded <= 1'b1;
            end
            if (w_start) begin
                r_error <= 1'b0;
            end else if (w_fail) begin
                r_error <= 1'b1;
            end
        end
    end

    assign key_ready           = w_busy;
    assign busy                = w_busy;
    assign working_locking_key = r_key;
    assign key_loaded          = r_loaded;
    assign key_error           = r_error;

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: two instances (TIMEOUT=16 and TIMEOUT=0) share directed stimulus
// and are compared every cycle against a bit-counting load model, plus literal spot checks.
module tb_lock_key_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       key_bit;
    logic       key_valid;

    logic       a_ready, a_loaded, a_error, a_busy;
    logic [7:0] a_key;
    logic       b_ready, b_loaded, b_error, b_busy;
    logic [7:0] b_key;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  check_en = 1'b0;

    // Model state, index 0 = TIMEOUT 16 instance, index 1 = TIMEOUT 0 instance.
    bit         m_act [2];
    int         m_n   [2];
    logic [7:0] m_acc [2];
    int         m_idle[2];
    logic [7:0] m_key [2];
    bit         m_ld  [2];
    bit         m_er  [2];

    always #5 clk = ~clk;

    lock_key_loader #(.KEY_WIDTH(8), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_bit(key_bit),
        .key_valid(key_valid), .key_ready(a_ready), .working_locking_key(a_key),
        .key_loaded(a_loaded), .key_error(a_error), .busy(a_busy)
    );

    lock_key_loader #(.KEY_WIDTH(8), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_bit(key_bit),
        .key_valid(key_valid), .key_ready(b_ready), .working_locking_key(b_key),
        .key_loaded(b_loaded), .key_error(b_error), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A load collects 8 data bits then one parity bit; idle cycles while loading count to the limit.
    task automatic model_step(input int i, input int limit);
        int ones;
        if (!rst_n) begin
            m_act[i] = 0; m_n[i] = 0; m_acc[i] = '0; m_idle[i] = 0;
            m_key[i] = '0; m_ld[i] = 0; m_er[i] = 0;
        end else if (m_act[i]) begin
            if (key_valid) begin
                m_idle[i] = 0;
                if (m_n[i] < 8) begin
                    m_acc[i] = m_acc[i] | (8'(key_bit) << m_n[i]);
                    m_n[i]++;
                end else begin
                    ones = $countones(m_acc[i]) + int'(key_bit);
                    if (ones % 2 == 0) begin
                        m_key[i] = m_acc[i];
                        m_ld[i]  = 1;
                    end else begin
                        m_er[i] = 1;
                    end
                    m_act[i] = 0;
                end
            end else if (limit > 0) begin
                m_idle[i]++;
                if (m_idle[i] == limit) begin
                    m_er[i]  = 1;
                    m_act[i] = 0;
                end
            end
        end else if (load_start) begin
            m_act[i] = 1; m_n[i] = 0; m_acc[i] = '0; m_idle[i] = 0; m_er[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 16);
        model_step(1, 0);
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("A.ready",  32'(a_ready),  32'(m_act[0]));
            chk("A.busy",   32'(a_busy),   32'(m_act[0]));
            chk("A.key",    32'(a_key),    32'(m_key[0]));
            chk("A.loaded", 32'(a_loaded), 32'(m_ld[0]));
            chk("A.error",  32'(a_error),  32'(m_er[0]));
            chk("B.ready",  32'(b_ready),  32'(m_act[1]));
            chk("B.busy",   32'(b_busy),   32'(m_act[1]));
            chk("B.key",    32'(b_key),    32'(m_key[1]));
            chk("B.loaded", 32'(b_loaded), 32'(m_ld[1]));
            chk("B.error",  32'(b_error),  32'(m_er[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        tick();
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; load_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;

        // 1: reset
        tick(); tick();
        check_en = 1'b1;
        chk("rst.key",    32'(a_key),    32'h00);
        chk("rst.loaded", 32'(a_loaded), 32'h0);
        chk("rst.error",  32'(a_error),  32'h0);
        chk("rst.ready",  32'(a_ready),  32'h0);
        chk("rst.busy",   32'(a_busy),   32'h0);
        rst_n = 1'b1;
        tick();

        // 2: good load of 0xA5 (four ones -> parity 0)
        v = 8'hA5;
        start();
        for (int i = 0; i < 8; i++) beat(v[i]);
        chk("good.pre_loaded", 32'(a_loaded), 32'h0);
        chk("good.pre_busy",   32'(a_busy),   32'h1);
        beat(1'b0);
        chk("good.key",    32'(a_key),    32'hA5);
        chk("good.loaded", 32'(a_loaded), 32'h1);
        chk("good.busy",   32'(a_busy),   32'h0);
        chk("good.B.key",  32'(b_key),    32'hA5);
        chk("model.A.key", 32'(m_key[0]), 32'hA5);

        // 3: 0x01 with parity 0 is odd overall -> rejected, old key kept
        v = 8'h01;
        start();
        for (int i = 0; i < 8; i++) beat(v[i]);
        beat(1'b0);
        chk("badpar.error",  32'(a_error),  32'h1);
        chk("badpar.key",    32'(a_key),    32'hA5);
        chk("badpar.loaded", 32'(a_loaded), 32'h1);
        chk("badpar.ready",  32'(a_ready),  32'h0);
        chk("model.A.err",   32'(m_er[0]),  32'h1);
        start();
        chk("restart.error", 32'(a_error),  32'h0);
        chk("restart.busy",  32'(a_busy),   32'h1);

        // 4: three beats then 16 idle cycles
        beat(1'b1); beat(1'b0); beat(1'b1);
        repeat (15) tick();
        chk("to.15.error", 32'(a_error), 32'h0);
        chk("to.15.busy",  32'(a_busy),  32'h1);
        tick();
        chk("to.16.error", 32'(a_error), 32'h1);
        chk("to.16.ready", 32'(a_ready), 32'h0);
        chk("to.16.key",   32'(a_key),   32'hA5);
        chk("to.B.busy",   32'(b_busy),  32'h1);
        chk("to.B.error",  32'(b_error), 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 5a: gappy 0x3C with a stray load_start mid-load
        v = 8'h3C;
        start();
        for (int i = 0; i < 8; i++) begin
            beat(v[i]);
            if (i == 3) begin
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
            end else begin
                tick();
            end
        end
        beat(1'b0);
        chk("gappy.key",    32'(a_key),    32'h3C);
        chk("gappy.loaded", 32'(a_loaded), 32'h1);
        chk("gappy.B.key",  32'(b_key),    32'h3C);

        // 5b: 100-cycle stall mid-load; only the timeout-free instance survives
        v = 8'h5A;
        start();
        beat(v[0]); beat(v[1]);
        repeat (100) tick();
        chk("stall.B.error", 32'(b_error), 32'h0);
        chk("stall.B.busy",  32'(b_busy),  32'h1);
        chk("stall.A.error", 32'(a_error), 32'h1);
        for (int i = 2; i < 8; i++) beat(v[i]);
        beat(1'b0);
        chk("stall.B.key",   32'(b_key),   32'h5A);
        chk("stall.B.error", 32'(b_error), 32'h0);
        chk("stall.A.key",   32'(a_key),   32'h3C);
        chk("model.B.key",   32'(m_key[1]), 32'h5A);

        // 6: reset after five beats
        v = 8'hFF;
        start();
        for (int i = 0; i < 5; i++) beat(v[i]);
        rst_n = 1'b0;
        tick();
        chk("midrst.key",    32'(a_key),    32'h00);
        chk("midrst.loaded", 32'(a_loaded), 32'h0);
        chk("midrst.error",  32'(a_error),  32'h0);
        chk("midrst.busy",   32'(a_busy),   32'h0);
        chk("midrst.B.key",  32'(b_key),    32'h00);
        rst_n = 1'b1;
        beat(1'b1);
        chk("postrst.ready", 32'(a_ready),  32'h0);
        tick();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
